// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for the iterative binary32 divider.
// master = operand source / result sink, slave = divider.
interface fp_div_if;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] a;
  logic [31:0] b;
  logic        quot_vld;
  logic [31:0] quot;
  logic        div_by_zero;

  modport master (
    output in_vld, a, b,
    input  in_rdy, quot_vld, quot, div_by_zero
  );

  modport slave (
    input  in_vld, a, b,
    output in_rdy, quot_vld, quot, div_by_zero
  );
endinterface

// File: rtl/fp_div.sv
// Iterative binary32 divider: one restoring quotient bit per cycle, truncation
// rounding, flush-to-zero; accept-to-result latency is fixed at 26 edges.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | in_rdy high, waiting for in_vld
//   DIV   | 25 restoring iterations, one quotient bit per cycle
//   NORM  | normalize, apply special cases, register result, pulse valid
module fp_div (
  input  logic    clk,
  input  logic    rst_n,
  fp_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               sign;
  logic signed [9:0]  exp_r;
  logic [25:0]        rem;
  logic [23:0]        dsr;
  logic               za;
  logic               zb;
  logic [24:0]        q;
  logic [4:0]         cnt;

  logic               accept;
  logic               rem_ge;
  logic signed [9:0]  e;
  logic [22:0]        mant;
  logic [31:0]        res;
  logic               res_dbz;

  assign bus.in_rdy = (state == IDLE);
  assign accept     = bus.in_vld && bus.in_rdy;
  assign rem_ge     = (rem >= {2'b00, dsr});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_vld) state_nxt = DIV;
      DIV:     if (cnt == 5'd0) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign  <= 1'b0;
      exp_r <= '0;
      rem   <= '0;
      dsr   <= '0;
      za    <= 1'b0;
      zb    <= 1'b0;
      q     <= '0;
      cnt   <= '0;
    end else if (accept) begin
      sign  <= bus.a[31] ^ bus.b[31];
      exp_r <= {2'b00, bus.a[30:23]} - {2'b00, bus.b[30:23]} + 10'd127;
      rem   <= {2'b00, 1'b1, bus.a[22:0]};
      dsr   <= {1'b1, bus.b[22:0]};
      za    <= (bus.a[30:23] == 8'd0);
      zb    <= (bus.b[30:23] == 8'd0);
      q     <= '0;
      cnt   <= 5'd24;
    end else if (state == DIV) begin
      // rem stays below 2*dsr, so the shifted-out MSB is always zero
      if (rem_ge) rem <= (rem - {2'b00, dsr}) << 1;
      else        rem <= rem << 1;
      q   <= {q[23:0], rem_ge};
      cnt <= cnt - 5'd1;
    end
  end

  // q lies in (0.5, 2): q[24] set means the quotient is already normalized
  always_comb begin
    e    = q[24] ? exp_r : exp_r - 10'sd1;
    mant = q[24] ? q[23:1] : q[22:0];
    res_dbz = 1'b0;
    if (za && zb) begin
      res     = 32'h7FC0_0000;
      res_dbz = 1'b1;
    end else if (zb) begin
      res     = {sign, 8'hFF, 23'h0};
      res_dbz = 1'b1;
    end else if (za) begin
      res = {sign, 31'h0};
    end else if (e >= 10'sd255) begin
      res = {sign, 8'hFF, 23'h0};
    end else if (e <= 10'sd0) begin
      res = {sign, 31'h0};
    end else begin
      res = {sign, e[7:0], mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.quot_vld    <= 1'b0;
      bus.quot        <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.quot_vld <= (state == NORM);
      if (state == NORM) begin
        bus.quot        <= res;
        bus.div_by_zero <= res_dbz;
      end
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: a cycle-count model of the handshake plus a real-arithmetic
// quotient reference, compared against the DUT on every falling edge.
module tb_fp_div;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fp_div_if bus ();

  fp_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_busy = 0;
  logic        m_vld  = 1'b0;
  logic [31:0] m_quot = 32'h0;
  logic        m_dbz  = 1'b0;
  logic [32:0] m_pend = 33'h0;
  int          pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // returns {div_by_zero, quot}
  function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic              s;
    int                ex, ey, e;
    longint unsigned   mx, my, qq;
    logic [22:0]       man;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ex == 0 && ey == 0) return {1'b1, 32'h7FC0_0000};
    if (ey == 0)            return {1'b1, s, 8'hFF, 23'h0};
    if (ex == 0)            return {1'b0, s, 31'h0};
    mx = 64'(1 << 23) + 64'(x[22:0]);
    my = 64'(1 << 23) + 64'(y[22:0]);
    qq = (mx << 24) / my;
    e  = ex - ey + 127;
    if (qq >= 64'd16777216) begin
      man = qq[23:1];
    end else begin
      man = qq[22:0];
      e   = e - 1;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
    if (e <= 0)   return {1'b0, s, 31'h0};
    return {1'b0, s, 8'(e), man};
  endfunction

  // handshake/latency model: busy for 26 edges after an accept, result on the last
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_vld  <= 1'b0;
      m_quot <= 32'h0;
      m_dbz  <= 1'b0;
    end else begin
      m_vld <= 1'b0;
      if (m_busy == 0) begin
        if (bus.in_vld) begin
          m_busy <= 26;
          m_pend <= ref_div(bus.a, bus.b);
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_vld  <= 1'b1;
          m_quot <= m_pend[31:0];
          m_dbz  <= m_pend[32];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_rdy", 32'(bus.in_rdy), 32'(m_busy == 0));
    chk("quot_vld", 32'(bus.quot_vld), 32'(m_vld));
    chk("quot", bus.quot, m_quot);
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
    if (bus.quot_vld) pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy != 0 && n < 100) begin step(); n++; end
    chk("idle_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic do_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eq, input logic ed);
    int n;
    wait_idle();
    bus.in_vld = 1'b1;
    bus.a      = av;
    bus.b      = bv;
    step();
    bus.in_vld = 1'b0;
    bus.a      = $urandom;
    bus.b      = $urandom;
    n = 0;
    while (!bus.quot_vld && n < 40) begin step(); n++; end
    chk({nm, "_latency"}, 32'(n), 32'd26);
    chk({nm, "_quot"}, bus.quot, eq);
    chk({nm, "_dbz"}, 32'(bus.div_by_zero), 32'(ed));
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 19);
    if (sel == 0)      v[30:23] = 8'h00;
    else if (sel == 1) v[30:23] = 8'hFF;
    else if (sel < 12) v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  initial begin
    logic [32:0] r;
    int          n;
    int          p0;
    bus.in_vld = 1'b0;
    bus.a      = 32'h0;
    bus.b      = 32'h0;
    #1 rst_n = 1'b0;

    // pin the reference model to hand-computed values
    r = ref_div(32'h40C0_0000, 32'h4000_0000); chk("ref_6_2", r[31:0], 32'h4040_0000);
    r = ref_div(32'h3F80_0000, 32'h4040_0000); chk("ref_1_3", r[31:0], 32'h3EAA_AAAA);
    r = ref_div(32'h3F80_0000, 32'h0000_0000); chk("ref_dbz", 32'(r), {31'h0, 1'b1, 32'h7F80_0000} >> 0 & 33'h1_FFFF_FFFF);
    r = ref_div(32'h0080_0000, 32'h7F00_0000); chk("ref_uflow", r[31:0], 32'h0);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("reset_rdy", 32'(bus.in_rdy), 32'd1);
    chk("reset_vld", 32'(bus.quot_vld), 32'd0);
    chk("reset_quot", bus.quot, 32'h0);

    do_op("basic",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    do_op("trunc",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0);
    do_op("neg3",    32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 1'b0);
    do_op("one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    do_op("x_div0",  32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1);
    do_op("nx_div0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1);
    do_op("0_div0",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1);
    do_op("0_div5",  32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0);
    do_op("oflow",   32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0);
    do_op("uflow",   32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0);

    // in_vld held high with a new operand every cycle: 5 accepts in 135 edges
    wait_idle();
    step();
    p0 = pulses;
    for (int i = 0; i < 27 * 5; i++) begin
      bus.in_vld = 1'b1;
      bus.a      = rnd_fp();
      bus.b      = rnd_fp();
      step();
    end
    bus.in_vld = 1'b0;
    repeat (30) step();
    chk("stream_pulses", 32'(pulses - p0), 32'd5);

    // reset in the middle of DIV abandons the operation
    wait_idle();
    bus.in_vld = 1'b1;
    bus.a      = 32'h40C0_0000;
    bus.b      = 32'h4000_0000;
    step();
    bus.in_vld = 1'b0;
    repeat (9) step();
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    chk("midreset_rdy", 32'(bus.in_rdy), 32'd1);
    chk("midreset_vld", 32'(bus.quot_vld), 32'd0);
    bus.in_vld = 1'b1;
    bus.a      = 32'hC0F0_0000;
    bus.b      = 32'h4020_0000;
    repeat (20) step();
    chk("midreset_no_pulse", 32'(pulses - p0), 32'd0);
    #1 rst_n = 1'b1;
    step();
    bus.in_vld = 1'b0;
    n = 0;
    while (!bus.quot_vld && n < 40) begin step(); n++; end
    chk("post_reset_latency", 32'(n), 32'd26);
    chk("post_reset_quot", bus.quot, 32'hC040_0000);

    // random operands with random idle gaps
    for (int i = 0; i < 150; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
      bus.in_vld = 1'b1;
      bus.a      = rnd_fp();
      bus.b      = rnd_fp();
      step();
      bus.in_vld = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 5)) step();
      bus.in_vld = 1'b0;
    end
    wait_idle();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
